// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller that drives an external 16-bit up/down counter.
// Supports one-shot or auto-reload operation, with a prescaler between count steps.
module countdown_timer_ctrl #(
   parameter int PRESCALE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        reload_en,
   input  logic [15:0] period,
   input  logic [15:0] cnt_Q,
   input  logic        cnt_DTC,
   output logic        cnt_UD,
   output logic        cnt_CE,
   output logic        cnt_LD,
   output logic [15:0] cnt_Din,
   output logic        busy,
   output logic        expired,
   output logic [15:0] remaining
);

   localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      EXPIRE = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [15:0]   period_lat;
   logic [PW-1:0] presc;
   logic          tick;
   logic          restart;
   logic          take_period;

   assign tick    = (presc == PMAX);
   assign restart = start && !stop && (period != 16'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // stop outranks start, which outranks the normal countdown flow
   always_comb begin
      state_nxt   = state;
      take_period = 1'b0;
      case (state)
         IDLE: begin
            if (restart) begin
               state_nxt   = LOAD;
               take_period = 1'b1;
            end
         end
         LOAD: begin
            state_nxt = stop ? IDLE : RUN;
         end
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (restart) begin
               state_nxt   = LOAD;
               take_period = 1'b1;
            end else if (cnt_DTC) begin
               state_nxt = EXPIRE;
            end
         end
         EXPIRE: begin
            if (!stop && reload_en && (period != 16'd0)) begin
               state_nxt   = LOAD;
               take_period = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_lat <= 16'd0;
         presc      <= '0;
      end else begin
         if (take_period) begin
            period_lat <= period;
         end
         if ((state == RUN) && !tick) begin
            presc <= presc + PW'(1);
         end else begin
            presc <= '0;
         end
      end
   end

   // CE is held off at terminal count and when stop arrives, so the counter never wraps
   always_comb begin
      cnt_UD    = 1'b0;
      cnt_LD    = (state == LOAD);
      cnt_CE    = (state == RUN) && tick && !cnt_DTC && !stop;
      busy      = (state == LOAD) || (state == RUN);
      expired   = (state == EXPIRE);
      remaining = busy ? cnt_Q : 16'd0;
   end

   assign cnt_Din = period_lat;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: two controllers (PRESCALE 1 and 4), each paired
// with a behavioural 16-bit down counter, driven from a vector table plus directed sequences.
module tb_countdown_timer_ctrl;

   logic clk;
   logic rst_n;
   logic init_n;

   logic        start1, stop1, reload1;
   logic [15:0] per1;
   logic [15:0] q1;
   logic        dtc1, ud1, ce1, ld1, busy1, exp1;
   logic [15:0] din1, rem1;

   logic        start4, stop4, reload4;
   logic [15:0] per4;
   logic [15:0] q4;
   logic        dtc4, ud4, ce4, ld4, busy4, exp4;
   logic [15:0] din4, rem4;

   int n_chk;
   int n_fail;
   int inv_viol;

   typedef struct {
      logic        st;
      logic        sp;
      logic [15:0] per;
      logic        ld;
      logic        ce;
      logic        busy;
      logic        ex;
      logic [15:0] din;
      logic [15:0] q;
      logic [15:0] rem;
   } vec_t;

   vec_t tbl[$];

   countdown_timer_ctrl #(.PRESCALE(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start1),
      .stop      (stop1),
      .reload_en (reload1),
      .period    (per1),
      .cnt_Q     (q1),
      .cnt_DTC   (dtc1),
      .cnt_UD    (ud1),
      .cnt_CE    (ce1),
      .cnt_LD    (ld1),
      .cnt_Din   (din1),
      .busy      (busy1),
      .expired   (exp1),
      .remaining (rem1)
   );

   countdown_timer_ctrl #(.PRESCALE(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start4),
      .stop      (stop4),
      .reload_en (reload4),
      .period    (per4),
      .cnt_Q     (q4),
      .cnt_DTC   (dtc4),
      .cnt_UD    (ud4),
      .cnt_CE    (ce4),
      .cnt_LD    (ld4),
      .cnt_Din   (din4),
      .busy      (busy4),
      .expired   (exp4),
      .remaining (rem4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter models: not touched by rst_n, only cleared once at time zero
   always @(posedge clk or negedge init_n) begin
      if (!init_n)  q1 <= 16'd0;
      else if (ld1) q1 <= din1;
      else if (ce1) q1 <= ud1 ? q1 + 16'd1 : q1 - 16'd1;
   end

   always @(posedge clk or negedge init_n) begin
      if (!init_n)  q4 <= 16'd0;
      else if (ld4) q4 <= din4;
      else if (ce4) q4 <= ud4 ? q4 + 16'd1 : q4 - 16'd1;
   end

   assign dtc1 = (q1 == 16'd0);
   assign dtc4 = (q4 == 16'd0);

   initial inv_viol = 0;
   always @(negedge clk) begin
      if (rst_n && ((ce1 && (ld1 || dtc1)) || (ce4 && (ld4 || dtc4))))
         inv_viol <= inv_viol + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic sp, input logic [15:0] per,
                      input logic ld, input logic ce, input logic busy, input logic ex,
                      input logic [15:0] din, input logic [15:0] q, input logic [15:0] rem);
      vec_t v;
      v.st = st; v.sp = sp; v.per = per;
      v.ld = ld; v.ce = ce; v.busy = busy; v.ex = ex;
      v.din = din; v.q = q; v.rem = rem;
      tbl.push_back(v);
   endtask

   initial begin
      int pk[4];
      int np;
      int first;

      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0; init_n = 1'b0;
      start1 = 0; stop1 = 0; reload1 = 0; per1 = 16'd0;
      start4 = 0; stop4 = 0; reload4 = 0; per4 = 16'd0;

      // one-shot period 5
      add(1,0,5, 1,0,1,0, 5,0,0);
      for (int j = 5; j >= 1; j--) add(0,0,5, 0,1,1,0, 5,16'(j),16'(j));
      add(0,0,5, 0,0,1,0, 5,0,0);
      add(0,0,5, 0,0,0,1, 5,0,0);
      add(0,0,5, 0,0,0,0, 5,0,0);
      // start with period 0 is ignored
      add(1,0,0, 0,0,0,0, 5,0,0);
      add(0,0,0, 0,0,0,0, 5,0,0);
      // start together with stop stays idle
      add(1,1,7, 0,0,0,0, 5,0,0);
      add(0,0,7, 0,0,0,0, 5,0,0);
      // stop while Q=2: idle next clock, counter holds, no expiry
      add(1,0,4, 1,0,1,0, 4,0,0);
      for (int j = 4; j >= 2; j--) add(0,0,4, 0,1,1,0, 4,16'(j),16'(j));
      add(0,1,4, 0,0,0,0, 4,2,0);
      add(0,0,4, 0,0,0,0, 4,2,0);
      add(0,0,4, 0,0,0,0, 4,2,0);
      // restart in RUN with period 9
      add(1,0,3, 1,0,1,0, 3,2,2);
      add(0,0,3, 0,1,1,0, 3,3,3);
      add(0,0,3, 0,1,1,0, 3,2,2);
      add(1,0,9, 1,0,1,0, 9,1,1);
      for (int j = 9; j >= 1; j--) add(0,0,9, 0,1,1,0, 9,16'(j),16'(j));
      add(0,0,9, 0,0,1,0, 9,0,0);
      add(0,0,9, 0,0,0,1, 9,0,0);
      add(0,0,9, 0,0,0,0, 9,0,0);

      #12;
      check("reset_p1", 64'({ud1,ld1,ce1,busy1,exp1,din1,rem1}), 64'(0));
      check("reset_p4", 64'({ud4,ld4,ce4,busy4,exp4,din4,rem4}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1; init_n = 1'b1;

      foreach (tbl[i]) begin
         start1 = tbl[i].st; stop1 = tbl[i].sp; per1 = tbl[i].per;
         @(posedge clk); #1;
         check($sformatf("vec%0d", i),
               64'({ud1,ld1,ce1,busy1,exp1,din1,rem1,q1}),
               64'({1'b0,tbl[i].ld,tbl[i].ce,tbl[i].busy,tbl[i].ex,tbl[i].din,tbl[i].rem,tbl[i].q}));
         @(negedge clk);
      end
      start1 = 0; stop1 = 0;

      // auto-reload, period 3: pulses every period+3 clocks
      start1 = 1; reload1 = 1; per1 = 16'd3;
      @(posedge clk); #1;
      @(negedge clk); start1 = 0;
      for (int j = 0; j < 4; j++) pk[j] = -1;
      np = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (exp1 && np < 4) begin pk[np] = k; np++; end
      end
      check("reload_first", 64'(pk[0]), 64'(5));
      for (int j = 1; j < 4; j++)
         check($sformatf("reload_gap%0d", j), 64'(pk[j] - pk[j-1]), 64'(6));
      @(negedge clk); stop1 = 1; reload1 = 0;
      @(negedge clk); stop1 = 0;
      check("reload_stop_busy", 64'(busy1), 64'(0));

      // PRESCALE=4, period 2 one-shot
      start4 = 1; per4 = 16'd2;
      @(posedge clk); #1;
      check("p4_load", 64'({ld4,ce4,busy4}), 64'(3'b101));
      @(negedge clk); start4 = 0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         check($sformatf("p4_k%0d", k), 64'({ce4,exp4,busy4}),
               64'({(k == 4 || k == 8), (k == 10), (k <= 9)}));
      end

      // PRESCALE=4 reload spacing
      @(negedge clk); start4 = 1; reload4 = 1; per4 = 16'd2;
      @(posedge clk); #1;
      @(negedge clk); start4 = 0;
      pk[0] = -1; pk[1] = -1; np = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (exp4 && np < 2) begin pk[np] = k; np++; end
      end
      check("p4_reload_first", 64'(pk[0]), 64'(10));
      check("p4_reload_gap", 64'(pk[1] - pk[0]), 64'(11));
      @(negedge clk); stop4 = 1; reload4 = 0;
      @(negedge clk); stop4 = 0;

      // async reset mid-RUN
      start1 = 1; per1 = 16'd5;
      @(posedge clk); #1;
      @(negedge clk); start1 = 0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_out", 64'({ud1,ld1,ce1,busy1,exp1,din1,rem1}), 64'(0));
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check($sformatf("frozen_q%0d", k), 64'({busy1,q1}), 64'({1'b0,16'd3}));
      end
      @(negedge clk); start1 = 1; per1 = 16'd2;
      @(posedge clk); #1;
      check("post_rst_load", 64'({ld1,din1}), 64'({1'b1,16'd2}));
      @(negedge clk); start1 = 0;
      first = -1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (exp1 && first < 0) first = k;
      end
      check("post_rst_expire", 64'(first), 64'(4));

      check("ce_invariants", 64'(inv_viol), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
